// File: rtl/switch_conditioner_pkg.sv
// Shared definitions for the switch conditioner: default sizes, the
// capture-handshake state type and the debounce counter width helper.
package switch_conditioner_pkg;

    // Default data width; the switch bus is two bits wider (enter + core reset).
    localparam int N_DEFAULT  = 8;
    // Default debounce qualification time in clock cycles.
    localparam int DB_DEFAULT = 16;

    // Capture register state: empty, or holding a word not yet acknowledged.
    typedef enum logic {
        CAP_EMPTY = 1'b0,
        CAP_HELD  = 1'b1
    } cap_state_t;

    // Counter wide enough to hold 0 .. db inclusive.
    function automatic int cnt_width(input int db);
        return $clog2(db + 1);
    endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Capture handshake bundle: the latched operator word, its valid flag,
// the consumer's acknowledge and the sticky overrun flag.
interface switch_conditioner_if #(
    parameter int n = switch_conditioner_pkg::N_DEFAULT
);
    logic [n-1:0] data_out;
    logic         data_valid;
    logic         data_ack;
    logic         overrun;

    // Producer side (the conditioner).
    modport master (
        output data_out,
        output data_valid,
        output overrun,
        input  data_ack
    );

    // Consumer side (the core / polling program).
    modport slave (
        input  data_out,
        input  data_valid,
        input  overrun,
        output data_ack
    );
endinterface

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch input: two-flop synchroniser, agreement-restart debounce
// counter, stable output flop and single-cycle rise/fall pulses.
module debounce_bit
    import switch_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DB_DEFAULT
) (
    input  logic clk,
    input  logic reset,      // asynchronous, active low
    input  logic i_raw,      // asynchronous switch pin
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int              CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    logic          w_differ;
    logic          w_flip;

    // The synchronised level disagrees with the stable one; it flips once it
    // has disagreed for DB_CYCLES consecutive evaluations.
    assign w_differ = (r_s2 != r_stable);
    assign w_flip   = w_differ && (r_cnt == CNT_LAST);

    // Two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Qualification counter; any cycle of agreement restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_differ) begin
            r_cnt    <= '0;
        end else if (w_flip) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Edge pulses registered on the same edge as the flip, so they coincide
    // with the first cycle the new stable value is visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_flip &  r_s2;
            r_fall <= w_flip & ~r_s2;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/switch_conditioner.sv
// Switch input stage for the picoMIPS core: conditions every switch bit,
// exposes edge pulses, and latches the low n bits as an operator word when
// the enter switch SW[n] rises, with valid/ack and a sticky overrun flag.
// SW[n+1] (the core's reset bit) is only conditioned; it never resets this
// block.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int n         = N_DEFAULT,
    parameter int DB_CYCLES = DB_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,     // asynchronous, active low
    input  logic [n+1:0]         SW_raw,
    output logic [n+1:0]         SW,
    output logic [n+1:0]         SW_rise,
    output logic [n+1:0]         SW_fall,
    switch_conditioner_if.master cap
);

    cap_state_t   r_state;
    logic [n-1:0] r_data;
    logic         r_overrun;

    logic         w_capture;
    logic         w_ack;

    // Independent conditioner per switch bit.
    generate
        for (genvar gi = 0; gi < n + 2; gi++) begin : g_bit
            debounce_bit #(
                .DB_CYCLES (DB_CYCLES)
            ) u_bit (
                .clk      (clk),
                .reset    (reset),
                .i_raw    (SW_raw[gi]),
                .o_stable (SW[gi]),
                .o_rise   (SW_rise[gi]),
                .o_fall   (SW_fall[gi])
            );
        end
    endgenerate

    assign w_capture = SW_rise[n];
    assign w_ack     = cap.data_ack;

    // Capture handshake. A new capture while a word is held either replaces
    // it (ack in the same cycle) or is dropped and flagged as overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= CAP_EMPTY;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                CAP_EMPTY: begin
                    if (w_capture) begin
                        r_data  <= SW[n-1:0];
                        r_state <= CAP_HELD;
                    end
                end
                CAP_HELD: begin
                    if (w_capture) begin
                        if (w_ack) begin
                            r_data <= SW[n-1:0];
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else if (w_ack) begin
                        r_state <= CAP_EMPTY;
                    end
                end
            endcase
        end
    end

    assign cap.data_out   = r_data;
    assign cap.data_valid = (r_state == CAP_HELD);
    assign cap.overrun    = r_overrun;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner with DB_CYCLES=4: stimulus pushes
// expected edge events and capture-register changes; a monitor pops and
// compares whenever the DUT shows a pulse or a handshake-state change.
module tb_switch_conditioner;

    localparam int N  = 8;
    localparam int DB = 4;
    localparam int L  = DB + 2;   // raw-to-SW latency in edges

    typedef struct {
        int         cyc;
        logic [9:0] sw;
        logic [9:0] rise;
        logic [9:0] fall;
    } edge_t;

    typedef struct {
        int         cyc;
        logic [7:0] dout;
        logic       valid;
        logic       ovr;
    } cap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] SW_raw;
    logic [9:0] SW;
    logic [9:0] SW_rise;
    logic [9:0] SW_fall;
    int         cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    edge_t eq[$];
    cap_t  cq[$];

    // Reference model state
    logic [9:0] exp_sw    = '0;
    logic [7:0] exp_dout  = '0;
    logic       exp_valid = 1'b0;
    logic       exp_ovr   = 1'b0;

    switch_conditioner_if #(.n(N)) cap_if ();

    switch_conditioner #(
        .n         (N),
        .DB_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .SW_raw  (SW_raw),
        .SW      (SW),
        .SW_rise (SW_rise),
        .SW_fall (SW_fall),
        .cap     (cap_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Push a capture record if the modelled handshake state changed.
    task automatic push_cap(input int c, input logic [7:0] d, input logic v, input logic o);
        if (d != exp_dout || v != exp_valid || o != exp_ovr) begin
            exp_dout  = d;
            exp_valid = v;
            exp_ovr   = o;
            cq.push_back('{c, d, v, o});
        end
    endtask

    // Present a new steady raw level; optionally ack in the cycle SW_rise[8] shows.
    task automatic apply(input logic [9:0] v, input logic ack_at_rise);
        int         c;
        logic [9:0] r;
        logic [9:0] f;
        c      = cyc;
        r      = v & ~exp_sw;
        f      = exp_sw & ~v;
        SW_raw = v;
        if ((r | f) != 0) eq.push_back('{c + L, v, r, f});
        exp_sw = v;
        if (r[8]) begin
            if (!exp_valid)      push_cap(c + L + 1, v[7:0], 1'b1, exp_ovr);
            else if (ack_at_rise) push_cap(c + L + 1, v[7:0], 1'b1, exp_ovr);
            else                  push_cap(c + L + 1, exp_dout, 1'b1, 1'b1);
        end
        repeat (L) @(negedge clk);
        if (ack_at_rise) cap_if.data_ack = 1'b1;
        @(negedge clk);
        cap_if.data_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One-cycle acknowledge; ignored by the DUT when nothing is held.
    task automatic ack_pulse();
        int c;
        c = cyc;
        cap_if.data_ack = 1'b1;
        if (exp_valid) push_cap(c + 1, exp_dout, 1'b0, exp_ovr);
        @(negedge clk);
        cap_if.data_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: compares pulses and handshake changes against the queues.
    initial begin
        logic [10:0] prev_cap;
        logic [10:0] cur_cap;
        edge_t       e;
        cap_t        k;
        prev_cap = '0;
        forever begin
            @(negedge clk);
            cur_cap = {cap_if.data_out, cap_if.data_valid, cap_if.overrun};
            if (reset) begin
                if ((SW_rise | SW_fall) != 0) begin
                    if (eq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL edge_unexpected: got rise=%h fall=%h sw=%h at cyc %0d, expected no pulse",
                                 SW_rise, SW_fall, SW, cyc);
                    end else begin
                        e = eq.pop_front();
                        check("edge_cycle", cyc, e.cyc);
                        check("edge_sw", {22'd0, SW}, {22'd0, e.sw});
                        check("edge_rise", {22'd0, SW_rise}, {22'd0, e.rise});
                        check("edge_fall", {22'd0, SW_fall}, {22'd0, e.fall});
                    end
                end
                if (cur_cap != prev_cap) begin
                    if (cq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL cap_unexpected: got dout=%h valid=%b ovr=%b at cyc %0d, expected no change",
                                 cap_if.data_out, cap_if.data_valid, cap_if.overrun, cyc);
                    end else begin
                        k = cq.pop_front();
                        check("cap_cycle", cyc, k.cyc);
                        check("cap_dout", {24'd0, cap_if.data_out}, {24'd0, k.dout});
                        check("cap_valid", {31'd0, cap_if.data_valid}, {31'd0, k.valid});
                        check("cap_overrun", {31'd0, cap_if.overrun}, {31'd0, k.ovr});
                    end
                end
            end
            prev_cap = cur_cap;
        end
    end

    // Stimulus
    initial begin
        int c;
        reset           = 1'b0;
        SW_raw          = 10'h3FF;
        cap_if.data_ack = 1'b0;

        // 1. Reset with all switches high, then release
        repeat (3) @(negedge clk);
        #1;
        check("rst_sw", {22'd0, SW}, 32'd0);
        check("rst_rise", {22'd0, SW_rise}, 32'd0);
        check("rst_fall", {22'd0, SW_fall}, 32'd0);
        check("rst_dout", {24'd0, cap_if.data_out}, 32'd0);
        check("rst_valid", {31'd0, cap_if.data_valid}, 32'd0);
        check("rst_overrun", {31'd0, cap_if.overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        apply(10'h3FF, 1'b0);
        ack_pulse();
        apply(10'h000, 1'b0);

        // 2. Glitch rejection on bit 3: 3 high, 1 low, 3 high
        SW_raw[3] = 1'b1; repeat (3) @(negedge clk);
        SW_raw[3] = 1'b0; @(negedge clk);
        SW_raw[3] = 1'b1; repeat (3) @(negedge clk);
        SW_raw[3] = 1'b0; repeat (10) @(negedge clk);
        check("glitch_sw3", {31'd0, SW[3]}, 32'd0);
        apply(10'h008, 1'b0);

        // 3. Capture 0xA5, ack, then a stray ack while empty
        apply(10'h0A5, 1'b0);
        apply(10'h1A5, 1'b0);
        ack_pulse();
        ack_pulse();
        apply(10'h0A5, 1'b0);
        apply(10'h1A5, 1'b0);

        // 4. Overrun: second rise with 0x3C while 0xA5 still held
        apply(10'h03C, 1'b0);
        apply(10'h13C, 1'b0);
        ack_pulse();

        // 5. Capture with simultaneous ack
        apply(10'h03C, 1'b0);
        apply(10'h13C, 1'b0);
        apply(10'h00F, 1'b0);
        apply(10'h10F, 1'b1);

        // 6. Reset mid-debounce (bit 5 counter at 2) and mid-handshake
        c      = cyc;
        SW_raw = 10'h12F;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_sw", {22'd0, SW}, 32'd0);
        check("mid_rst_dout", {24'd0, cap_if.data_out}, 32'd0);
        check("mid_rst_valid", {31'd0, cap_if.data_valid}, 32'd0);
        check("mid_rst_overrun", {31'd0, cap_if.overrun}, 32'd0);
        check("mid_rst_cycle", cyc, c + 4);
        exp_sw    = '0;
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply(10'h12F, 1'b0);

        repeat (5) @(negedge clk);
        check("edge_queue_empty", eq.size(), 32'd0);
        check("cap_queue_empty", cq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
